// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states and the
// state-only strobe decode used to build the registered control outputs.
package alu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    ARITH    = 4'd2,
    MUL_EVAL = 4'd3,
    MUL_SHR  = 4'd4,
    DIV_SHL  = 4'd5,
    DIV_OP   = 4'd6,
    DIV_SETQ = 4'd7,
    DIV_CORR = 4'd8,
    DONE     = 4'd9
  } state_e;

  typedef struct packed {
    logic ld_m;
    logic ld_q;
    logic ld_a;
    logic clr_a;
    logic alu_add;
    logic alu_sub;
    logic shr;
    logic shl;
    logic q0_wr;
    logic busy;
    logic done;
  } strb_t;

  // Strobes that depend on the state (and latched op) alone; data-dependent
  // add/sub decisions are layered on top in the controller.
  function automatic strb_t decode_state(input state_e st, input op_e op);
    strb_t s;
    s = '0;
    case (st)
      IDLE: begin
        s.busy = 1'b0;
      end
      LOAD: begin
        s.busy = 1'b1;
        s.ld_m = 1'b1;
        if ((op == OP_ADD) || (op == OP_SUB)) begin
          s.ld_a = 1'b1;
        end else begin
          s.ld_q  = 1'b1;
          s.clr_a = 1'b1;
        end
      end
      ARITH: begin
        s.busy = 1'b1;
        if (op == OP_ADD) begin
          s.alu_add = 1'b1;
        end else begin
          s.alu_sub = 1'b1;
        end
      end
      MUL_SHR: begin
        s.busy = 1'b1;
        s.shr  = 1'b1;
      end
      DIV_SHL: begin
        s.busy = 1'b1;
        s.shl  = 1'b1;
      end
      DIV_SETQ: begin
        s.busy  = 1'b1;
        s.q0_wr = 1'b1;
      end
      DONE: begin
        s.busy = 1'b1;
        s.done = 1'b1;
      end
      default: begin
        s.busy = 1'b1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiply/divide loops; saturates at WIDTH-1.
module iter_counter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: clear wins, increment stops at the last iteration.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the A/Q/M ALU datapath: add, sub, Booth multiply and
// non-restoring divide, driven through a start/busy/done handshake.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       div_zero,
  input  logic       q0,
  input  logic       q_m1,
  input  logic       a_msb,
  output logic       ld_m,
  output logic       ld_q,
  output logic       ld_a,
  output logic       clr_a,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       shr,
  output logic       shl,
  output logic       q0_wr,
  output logic       q0_val,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   err_q, err_d;
  strb_t  strb_q;
  logic   cnt_clr_s, cnt_inc_s, cnt_last_s;
  logic   mealy_add_s, mealy_sub_s;

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .clr_i   (cnt_clr_s),
    .inc_i   (cnt_inc_s),
    .last_o  (cnt_last_s)
  );

  // Next-state, op latch, error flag and counter control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op_e'(op);
          if ((op_e'(op) == OP_DIV) && div_zero) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_clr_s = 1'b1;
        case (op_q)
          OP_ADD, OP_SUB: state_d = ARITH;
          OP_MUL:         state_d = MUL_EVAL;
          default:        state_d = DIV_SHL;
        endcase
      end
      ARITH:    state_d = DONE;
      MUL_EVAL: state_d = MUL_SHR;
      MUL_SHR: begin
        if (cnt_last_s) begin
          state_d = DONE;
        end else begin
          cnt_inc_s = 1'b1;
          state_d   = MUL_EVAL;
        end
      end
      DIV_SHL: state_d = DIV_OP;
      DIV_OP:  state_d = DIV_SETQ;
      DIV_SETQ: begin
        if (cnt_last_s) begin
          state_d = DIV_CORR;
        end else begin
          cnt_inc_s = 1'b1;
          state_d   = DIV_SHL;
        end
      end
      DIV_CORR: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Data-dependent add/sub: Booth pair in MUL_EVAL, sign of A in divide.
  always_comb begin
    mealy_add_s = 1'b0;
    mealy_sub_s = 1'b0;
    case (state_q)
      MUL_EVAL: begin
        mealy_add_s = ~q0 & q_m1;
        mealy_sub_s = q0 & ~q_m1;
      end
      DIV_OP: begin
        mealy_add_s = a_msb;
        mealy_sub_s = ~a_msb;
      end
      DIV_CORR: begin
        mealy_add_s = a_msb;
      end
      default: begin
        mealy_add_s = 1'b0;
        mealy_sub_s = 1'b0;
      end
    endcase
  end

  // State, latched op, error flag and state-decoded strobes registered together.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      err_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      strb_q  <= decode_state(state_d, op_d);
    end
  end

  assign ld_m    = strb_q.ld_m;
  assign ld_q    = strb_q.ld_q;
  assign ld_a    = strb_q.ld_a;
  assign clr_a   = strb_q.clr_a;
  assign alu_add = strb_q.alu_add | mealy_add_s;
  assign alu_sub = strb_q.alu_sub | mealy_sub_s;
  assign shr     = strb_q.shr;
  assign shl     = strb_q.shl;
  assign q0_wr   = strb_q.q0_wr;
  assign q0_val  = strb_q.q0_wr & ~a_msb;
  assign busy    = strb_q.busy;
  assign done    = strb_q.done;
  assign err     = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural A/Q/M datapath model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       div_zero = 1'b0;
  logic       q0, q_m1, a_msb;
  logic       ld_m, ld_q, ld_a, clr_a, alu_add, alu_sub, shr, shl;
  logic       q0_wr, q0_val, busy, done, err;

  logic [7:0] bus_a = 8'h00, bus_q = 8'h00, bus_m = 8'h00;
  logic [7:0] m_a = 8'h00, m_q = 8'h00, m_m = 8'h00;
  logic       m_qm1 = 1'b0;

  int ncmp = 0;
  int nfail = 0;
  int done_cnt = 0, shl_cnt = 0, q0wr_cnt = 0, shr_cnt = 0, act_cnt = 0, excl_cnt = 0;
  logic in_mul = 1'b0;
  logic add_log [0:63];
  logic sub_log [0:63];

  alu_seq_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .div_zero(div_zero),
    .q0(q0), .q_m1(q_m1), .a_msb(a_msb),
    .ld_m(ld_m), .ld_q(ld_q), .ld_a(ld_a), .clr_a(clr_a),
    .alu_add(alu_add), .alu_sub(alu_sub), .shr(shr), .shl(shl),
    .q0_wr(q0_wr), .q0_val(q0_val), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign q0    = m_q[0];
  assign q_m1  = m_qm1;
  assign a_msb = m_a[7];

  // Datapath model plus strobe statistics, updated on the active edge.
  always @(posedge clk) begin
    if (ld_m) m_m <= bus_m;
    if (ld_a)         m_a <= bus_a;
    else if (clr_a)   m_a <= 8'h00;
    else if (alu_add) m_a <= m_a + m_m;
    else if (alu_sub) m_a <= m_a - m_m;
    else if (shr)     m_a <= {m_a[7], m_a[7:1]};
    else if (shl)     m_a <= {m_a[6:0], m_q[7]};
    if (ld_q) begin
      m_q <= bus_q; m_qm1 <= 1'b0;
    end else if (shr) begin
      m_q <= {m_a[0], m_q[7:1]}; m_qm1 <= m_q[0];
    end else if (shl) begin
      m_q <= {m_q[6:0], 1'b0};
    end else if (q0_wr) begin
      m_q <= {m_q[7:1], q0_val};
    end
    if (done)  done_cnt <= done_cnt + 1;
    if (shl)   shl_cnt  <= shl_cnt + 1;
    if (shr)   shr_cnt  <= shr_cnt + 1;
    if (q0_wr) q0wr_cnt <= q0wr_cnt + 1;
    if (|{ld_m, ld_q, ld_a, clr_a, alu_add, alu_sub, shr, shl, q0_wr}) act_cnt <= act_cnt + 1;
    if ($countones({alu_add, alu_sub, shr, shl, q0_wr}) > 1) excl_cnt <= excl_cnt + 1;
    if (in_mul && !shr && !ld_m && !done) begin
      add_log[shr_cnt] <= alu_add;
      sub_log[shr_cnt] <= alu_sub;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request at a falling edge; returns at the falling edge inside cycle 1.
  task automatic start_op(input logic [1:0] o, input logic dz,
                          input logic [7:0] a, input logic [7:0] q, input logic [7:0] m);
    bus_a = a; bus_q = q; bus_m = m;
    op = o; div_zero = dz; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; div_zero = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int d0, a0, s0, w0;

  initial begin
    #1;
    chk("reset_outputs", {3'b000, ld_m, ld_q, ld_a, clr_a, alu_add, alu_sub, shr, shl,
                          q0_wr, q0_val, busy, done, err}, 16'h0000);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Booth multiply 5 x -3
    in_mul = 1'b1;
    d0 = done_cnt;
    start_op(2'b10, 1'b0, 8'h00, 8'hFD, 8'h05);
    wait_done(1, cyc);
    in_mul = 1'b0;
    chk("mul_done_cycle", 16'(cyc), 16'd18);
    chk("mul_result", {m_a, m_q}, 16'hFFF1);
    chk("mul_err", {15'd0, err}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_add_it%0d", i), {15'd0, add_log[i]}, (i == 1) ? 16'd1 : 16'd0);
      chk($sformatf("mul_sub_it%0d", i), {15'd0, sub_log[i]}, (i == 0 || i == 2) ? 16'd1 : 16'd0);
    end
    @(negedge clk);
    chk("done_one_cycle", {14'd0, busy, done}, 16'h0000);
    chk("mul_done_count", 16'(done_cnt - d0), 16'd1);

    // Divide 100 / 7
    s0 = shl_cnt; w0 = q0wr_cnt;
    start_op(2'b11, 1'b0, 8'h00, 8'd100, 8'd7);
    wait_done(1, cyc);
    chk("div_done_cycle", 16'(cyc), 16'd27);
    chk("div_quot", {8'h00, m_q}, 16'd14);
    chk("div_rem", {8'h00, m_a}, 16'd2);
    chk("div_shl_count", 16'(shl_cnt - s0), 16'd8);
    chk("div_q0wr_count", 16'(q0wr_cnt - w0), 16'd8);
    @(negedge clk);

    // Divide by zero
    a0 = act_cnt;
    start_op(2'b11, 1'b1, 8'h00, 8'd50, 8'd0);
    wait_done(1, cyc);
    chk("dz_done_cycle", 16'(cyc), 16'd1);
    chk("dz_err", {15'd0, err}, 16'd1);
    repeat (3) @(negedge clk);
    chk("dz_no_strobes", 16'(act_cnt - a0), 16'd0);
    chk("dz_err_held", {14'd0, busy, err}, 16'd1);

    // Add 0x7F + 0x01
    start_op(2'b00, 1'b0, 8'h7F, 8'h00, 8'h01);
    chk("add_c1_loads", {12'd0, ld_a, ld_m, ld_q, err}, 16'b1100);
    @(negedge clk);
    chk("add_c2_alu", {14'd0, alu_add, alu_sub}, 16'b10);
    @(negedge clk);
    chk("add_c3_done", {15'd0, done}, 16'd1);
    chk("add_result", {8'h00, m_a}, 16'h0080);
    @(negedge clk);

    // Sub 0x7F - 0x01
    start_op(2'b01, 1'b0, 8'h7F, 8'h00, 8'h01);
    wait_done(1, cyc);
    chk("sub_done_cycle", 16'(cyc), 16'd3);
    chk("sub_result", {8'h00, m_a}, 16'h007E);
    @(negedge clk);

    // Multiply with a stray start in cycle 5
    d0 = done_cnt;
    start_op(2'b10, 1'b0, 8'h00, 8'hFD, 8'h05);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    chk("stray_busy", {15'd0, busy}, 16'd1);
    wait_done(6, cyc);
    chk("stray_done_cycle", 16'(cyc), 16'd18);
    chk("stray_result", {m_a, m_q}, 16'hFFF1);
    repeat (3) @(negedge clk);
    chk("stray_done_count", 16'(done_cnt - d0), 16'd1);

    // Async reset in cycle 9 of a divide, then a fresh multiply
    start_op(2'b11, 1'b0, 8'h00, 8'd100, 8'd7);
    repeat (8) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("rst_outputs", {3'b000, ld_m, ld_q, ld_a, clr_a, alu_add, alu_sub, shr, shl,
                        q0_wr, q0_val, busy, done, err}, 16'h0000);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    start_op(2'b10, 1'b0, 8'h00, 8'd3, 8'd2);
    wait_done(1, cyc);
    chk("rst_mul_done_cycle", 16'(cyc), 16'd18);
    chk("rst_mul_result", {m_a, m_q}, 16'h0006);
    @(negedge clk);

    chk("strobe_exclusive", 16'(excl_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
